// File: rtl/req_rsp_responder_pkg.sv
// Shared types for the request/response responder: response status codes and the
// response entry carried through the latency pipeline and response FIFO.
package req_rsp_responder_pkg;

  // rdata field is sized for the widest data bus this block is built with
  localparam int RSP_DATA_MAX = 32;

  typedef enum logic [1:0] {
    RSP_OKAY   = 2'b00,
    RSP_SLVERR = 2'b10
  } rsp_status_t;

  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    rsp_status_t             status;
    logic                    write;
  } rsp_entry_t;

  function automatic rsp_status_t status_for(input logic in_range);
    return in_range ? RSP_OKAY : RSP_SLVERR;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: push lands at the edge, head visible right after; head reads zero when empty.
// Push is dropped when full unless a pop happens on the same edge; pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/req_rsp_responder.sv
// Memory-backed request/response target: rsp_valid can rise RSP_LATENCY cycles after the accepting edge,
// handshake one cycle later at the earliest; req_ready drops once FIFO_DEPTH requests are outstanding.
module req_rsp_responder
  import req_rsp_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 64,
  parameter int RSP_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_status,
  output logic                  rsp_write
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic             req_fire;
  logic             rsp_fire;
  logic             in_range;
  logic [IDX_W-1:0] mem_idx;
  logic [CNT_W-1:0] outstanding;
  logic             rdy_en;
  rsp_entry_t       new_ent;
  rsp_entry_t       pipe_dat [RSP_LATENCY];
  logic [RSP_LATENCY-1:0] pipe_vld;
  rsp_entry_t       head;
  logic [$bits(rsp_entry_t)-1:0] fifo_head;
  logic             fifo_empty;

  assign req_fire = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;
  assign in_range = ({1'b0, req_addr} < MEM_LIMIT);
  assign mem_idx  = req_addr[IDX_W-1:0];

  always_comb begin
    new_ent        = '0;
    new_ent.write  = req_write;
    new_ent.status = status_for(in_range);
    if (in_range && !req_write) new_ent.rdata = RSP_DATA_MAX'(mem[mem_idx]);
  end

  always_ff @(posedge clk) begin
    if (req_fire && req_write && in_range) mem[mem_idx] <= req_wdata;
  end

  // Fixed-length shift pipeline; it can never stall because the counter bounds total occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RSP_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= req_fire;
      pipe_dat[0] <= new_ent;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      rdy_en      <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // rdy_en only holds ready low through reset and the edge that releases it
  assign req_ready = rdy_en & (outstanding < DEPTH_C);

  sync_fifo #(
    .WIDTH($bits(rsp_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pipe_vld[RSP_LATENCY-1]),
    .push_dat (pipe_dat[RSP_LATENCY-1]),
    .pop      (rsp_ready),
    .head_dat (fifo_head),
    .empty    (fifo_empty)
  );

  assign head       = fifo_head;
  assign rsp_valid  = ~fifo_empty;
  assign rsp_rdata  = DATA_WIDTH'(head.rdata);
  assign rsp_status = head.status;
  assign rsp_write  = head.write;

endmodule

// File: tb/tb_req_rsp_responder.sv
// Scoreboard bench for req_rsp_responder: a reference memory predicts each response at acceptance.
module tb_req_rsp_responder;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
    logic        write;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        rsp_write;

  req_rsp_responder #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_WORDS(64), .RSP_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_write(rsp_write)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_rsp = 0;
  int   last_acc_cyc = 0;
  int   first_acc_cyc = -1;
  int   rise_cyc = 0;
  bit   prev_vld = 1'b0;
  int   rsp_mode = 1;
  req_t tx_q[$];
  exp_t sb[$];
  logic [31:0] ref_mem [64];
  bit          ref_def [64];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input logic w, input logic [7:0] a, input logic [31:0] d);
    req_t r;
    r.write = w;
    r.addr  = a;
    r.wdata = d;
    tx_q.push_back(r);
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, model the coming rising edge
  task automatic step();
    req_t r;
    exp_t e;
    int   a;
    if (tx_q.size() > 0) begin
      r = tx_q[0];
      req_valid = 1'b1;
      req_write = r.write;
      req_addr  = r.addr;
      req_wdata = r.wdata;
    end else begin
      req_valid = 1'b0;
    end
    case (rsp_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (rsp_valid && !prev_vld) rise_cyc = cyc;
    prev_vld = rsp_valid;
    if (req_valid && req_ready) begin
      r = tx_q.pop_front();
      a = int'(r.addr);
      e.write    = r.write;
      e.rdata    = '0;
      e.chk_data = 1'b1;
      e.status   = (a < 64) ? 2'b00 : 2'b10;
      if (a < 64) begin
        if (r.write) begin
          ref_mem[a] = r.wdata;
          ref_def[a] = 1'b1;
        end else begin
          e.rdata    = ref_mem[a];
          e.chk_data = ref_def[a];
        end
      end
      sb.push_back(e);
      n_acc++;
      last_acc_cyc = cyc;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check_val("spurious_rsp", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check_val("rsp_status", 64'(rsp_status), 64'(e.status));
        check_val("rsp_write", 64'(rsp_write), 64'(e.write));
        if (e.chk_data) check_val("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((tx_q.size() != 0 || sb.size() != 0) && k < bound) begin
      step();
      k++;
    end
    check_val("drain_done", 64'((tx_q.size() == 0 && sb.size() == 0) ? 1 : 0), 64'(1));
  endtask

  initial begin
    int acc0;
    int r0;
    for (int i = 0; i < 64; i++) ref_def[i] = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 64'(req_ready), 64'(0));
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_val("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check_val("rst_rsp_status", 64'(rsp_status), 64'(0));
    check_val("rst_rsp_write", 64'(rsp_write), 64'(0));
    rst_n = 1'b1;
    #1 check_val("rel_ready_before_edge", 64'(req_ready), 64'(0));
    @(negedge clk);
    check_val("rel_ready_after_edge", 64'(req_ready), 64'(1));

    // write then read back, with latency from accept to first rsp_valid
    rsp_mode = 1;
    push_req(1'b1, 8'h05, 32'hDEADBEEF);
    drain(50);
    check_val("wr_latency", 64'(rise_cyc - last_acc_cyc), 64'(3));
    push_req(1'b0, 8'h05, 32'h0);
    drain(50);
    check_val("rd_latency", 64'(rise_cyc - last_acc_cyc), 64'(3));

    // out-of-range accesses must not alias onto real words
    push_req(1'b1, 8'h00, 32'h11111111);
    push_req(1'b1, 8'h3F, 32'h3F3F3F3F);
    push_req(1'b0, 8'h40, 32'h0);
    push_req(1'b1, 8'hFF, 32'h00000BAD);
    push_req(1'b1, 8'h40, 32'h0000BAD2);
    push_req(1'b0, 8'h00, 32'h0);
    push_req(1'b0, 8'h3F, 32'h0);
    drain(100);

    // backpressure: only FIFO_DEPTH accepted while responses are held
    rsp_mode = 0;
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) push_req(1'b1, 8'(20 + i), $urandom);
    for (int i = 0; i < 5; i++) push_req(1'b0, 8'(20 + i), 32'h0);
    run(12);
    #1;
    check_val("bp_accepted", 64'(n_acc - acc0), 64'(4));
    check_val("bp_req_ready", 64'(req_ready), 64'(0));
    check_val("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    rsp_mode = 1;
    drain(200);
    check_val("bp_total", 64'(n_acc - acc0), 64'(10));

    // back-to-back streaming
    for (int i = 0; i < 20; i++) push_req(1'b1, 8'(i), $urandom);
    for (int i = 0; i < 20; i++) push_req(1'b0, 8'(i), 32'h0);
    first_acc_cyc = -1;
    acc0 = n_acc;
    drain(300);
    check_val("b2b_count", 64'(n_acc - acc0), 64'(40));
    check_val("b2b_span", 64'(last_acc_cyc - first_acc_cyc), 64'(39));

    // reset with responses outstanding
    rsp_mode = 0;
    for (int i = 0; i < 3; i++) push_req(1'b0, 8'(i), 32'h0);
    run(6);
    check_val("pre_rst_valid", 64'(rsp_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(rsp_valid), 64'(0));
    check_val("mid_rst_ready", 64'(req_ready), 64'(0));
    check_val("mid_rst_rdata", 64'(rsp_rdata), 64'(0));
    tx_q.delete();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_vld = 1'b0;
    #1 check_val("post_rst_ready_pre", 64'(req_ready), 64'(0));
    @(negedge clk);
    check_val("post_rst_ready", 64'(req_ready), 64'(1));
    rsp_mode = 1;
    r0 = n_rsp;
    run(10);
    check_val("stale_rsp", 64'(n_rsp - r0), 64'(0));

    // randomized traffic with random response backpressure
    rsp_mode = 2;
    acc0 = n_acc;
    for (int i = 0; i < 1000; i++)
      push_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 71)), $urandom);
    drain(20000);
    check_val("rand_total", 64'(n_acc - acc0), 64'(1000));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
